mem_stage: RTL

- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Performs the data-memory access over a req/ack bus and resolves branch/jump PC select.
- Holds the pipeline with a stall while memory is busy. Drives a built-in MEM/WB register toward writeback.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/memwb_reg.sv | 27 ++
 rtl/mem_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS MEM stage: FSM encodings, bus defaults
// and the MEM/WB payload layout.
package mips_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] readdata;
        logic [31:0] result;
        logic [4:0]  wreg;
    } memwb_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register. While disabled (pipeline stalled) the payload is
// held but regwrite is cleared so writeback never retires a stalled slot twice.
module memwb_reg
    import mips_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   i_en,
    input  memwb_t i_d,
    output memwb_t o_q
);

    memwb_t r_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q.regwrite <= 1'b0;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory access over a req/ack bus with timeout, branch
// and jump select, pipeline stall generation and the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] iInstr,
    input  logic        iRegWrite,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iMemToReg,
    input  logic        iBranch,
    input  logic        iJump,
    input  logic [31:0] iB,
    input  logic [31:0] iResult,
    input  logic        iZero,
    input  logic [31:0] inextPCBranch,
    input  logic [31:0] iNPC1,
    input  logic [31:0] iPC,
    input  logic [4:0]  iwriteRegWire,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        oStall,
    output logic        oPCSrc,
    output logic        oJump,
    output logic [31:0] oInstr,
    output logic [31:0] oPC,
    output logic        oRegWrite,
    output logic        oMemToReg,
    output logic [31:0] oReadData,
    output logic [31:0] oResult,
    output logic [4:0]  owriteRegWire,
    output logic        oBusErr
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic   w_memop;
    logic   w_misaligned;
    logic   w_start;
    logic   w_timeout;
    logic   w_no_wb;
    memwb_t w_memwb_d;
    memwb_t w_memwb_q;

    // The branch target itself is muxed upstream; PC+4 is not needed here.
    logic w_unused_npc;
    assign w_unused_npc = ^{iNPC1, inextPCBranch};

    assign w_memop      = iMemRead | iMemWrite;
    assign w_misaligned = !is_word_aligned(iResult[1:0]);
    assign w_start      = (r_state == ST_IDLE) && w_memop && !w_misaligned;
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));

    assign oStall = w_start || (r_state == ST_WAIT);
    assign oPCSrc = iBranch & iZero;
    assign oJump  = iJump;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            oBusErr    <= 1'b0;
        end else begin
            oBusErr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_memop) begin
                        if (w_misaligned) begin
                            oBusErr <= 1'b1;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= iMemWrite;
                            dmem_addr  <= iResult;
                            dmem_wdata <= iB;
                            r_cnt      <= '0;
                            r_state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        r_rdata  <= dmem_we ? '0 : dmem_rdata;
                        r_err    <= 1'b0;
                        r_state  <= ST_DONE;
                    end else if (w_timeout) begin
                        dmem_req <= 1'b0;
                        oBusErr  <= 1'b1;
                        r_rdata  <= '0;
                        r_err    <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Failed accesses (misaligned now, or timed out in WAIT) must not retire a write.
    assign w_no_wb = ((r_state == ST_IDLE) && w_memop && w_misaligned)
                   || ((r_state == ST_DONE) && r_err);

    always_comb begin
        w_memwb_d          = '0;
        w_memwb_d.instr    = iInstr;
        w_memwb_d.pc       = iPC;
        w_memwb_d.regwrite = iRegWrite & ~w_no_wb;
        w_memwb_d.memtoreg = iMemToReg;
        w_memwb_d.readdata = (r_state == ST_DONE) ? r_rdata : '0;
        w_memwb_d.result   = iResult;
        w_memwb_d.wreg     = iwriteRegWire;
    end

    memwb_reg u_memwb (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (~oStall),
        .i_d     (w_memwb_d),
        .o_q     (w_memwb_q)
    );

    assign oInstr        = w_memwb_q.instr;
    assign oPC           = w_memwb_q.pc;
    assign oRegWrite     = w_memwb_q.regwrite;
    assign oMemToReg     = w_memwb_q.memtoreg;
    assign oReadData     = w_memwb_q.readdata;
    assign oResult       = w_memwb_q.result;
    assign owriteRegWire = w_memwb_q.wreg;

endmodule
